// File: rtl/gw_arb_pkg.sv
// Shared definitions for the register-bank write arbiter.
//   state_t : arbiter FSM encoding (IDLE / WRITE / LOCKED)
//   clog2   : ceiling log2 used to size the rr pointer and lock counter
package gw_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   mask  : requesters excluded from this pick
//   ptr   : highest-priority index for this pick
//   grant : one-hot grant (zero when nothing eligible)
//   idx   : index of the granted requester
//   valid : a grant was made
module rr_pick
    import gw_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    logic [NREQ-1:0] elig;
    logic [PW-1:0]   j;

    // Scan ptr, ptr+1, ... (mod NREQ); first eligible requester wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = '0;
        elig  = req & ~mask;
        for (int k = 0; k < int'(NREQ); k++) begin
            j = PW'((32'(ptr) + 32'(k)) % NREQ);
            if (!valid && elig[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/regbank_ce_arbiter.sv
// Round-robin arbiter sharing one write port (CE vector + D bus) of a
// clock-enabled flop bank among NREQ requesters.
//   CLK, RESETN : clock, async active-low reset
//   REQ/ADDR/WDATA/LOCK : per-requester write request, word address, data, lock
//   ACK  : one-cycle accept pulse per requester
//   CE/D : one-hot word enable and data to the bank (registered)
//   ERR  : granted address out of range (no word written)
//   BUSY : a write is issuing or a lock is held
// Optional feature: define ARB_LOCK_EN to enable burst locking (LOCKED state,
// up to LOCK_MAX back-to-back writes for one requester).
module regbank_ce_arbiter
    import gw_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned NREG     = 8,
    parameter int unsigned DW       = 8,
    parameter int unsigned AW       = 3,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ*AW-1:0] ADDR,
    input  logic [NREQ*DW-1:0] WDATA,
    input  logic [NREQ-1:0]   LOCK,
    output logic [NREQ-1:0]   ACK,
    output logic [NREG-1:0]   CE,
    output logic [DW-1:0]     D,
    output logic              ERR,
    output logic              BUSY
);

    localparam int unsigned PW = clog2(NREQ);
    localparam int unsigned CW = clog2(LOCK_MAX + 1);

    state_t          state, state_next;
    logic [PW-1:0]   ptr, ptr_next;

    logic [NREQ-1:0] pick_grant;
    logic [PW-1:0]   pick_idx;
    logic            pick_valid;

    logic            gnt_valid;
    logic [PW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt_vec;
    logic [AW-1:0]   gnt_addr;

    logic [NREQ-1:0] ack_next;
    logic [NREG-1:0] ce_next;
    logic [DW-1:0]   d_next;
    logic            err_next;
    logic            busy_next;

    // Requesters acked this cycle are masked so a held REQ is not written twice.
    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (REQ),
        .mask  (ACK),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef ARB_LOCK_EN
    logic [PW-1:0] owner, owner_next;
    logic [CW-1:0] lock_cnt, lock_cnt_next;
    logic          lock_hold;

    // Owner keeps the port while it still requests with LOCK and budget remains.
    assign lock_hold = (state == ST_LOCKED) && REQ[owner] && LOCK[owner]
                       && (lock_cnt < CW'(LOCK_MAX));
`else
    logic [NREQ+CW-1:0] unused_lock;
    assign unused_lock = {LOCK, CW'(LOCK_MAX)};
`endif

    // State register.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, grant decision and pointer/lock bookkeeping.
    always_comb begin
        state_next = ST_IDLE;
        ptr_next   = ptr;
        gnt_valid  = 1'b0;
        gnt_idx    = '0;
        gnt_vec    = '0;
`ifdef ARB_LOCK_EN
        owner_next    = owner;
        lock_cnt_next = lock_cnt;
        if (lock_hold) begin
            state_next      = ST_LOCKED;
            gnt_valid       = 1'b1;
            gnt_idx         = owner;
            gnt_vec[owner]  = 1'b1;
            lock_cnt_next   = lock_cnt + CW'(1);
        end else
`endif
        if (pick_valid) begin
            state_next = ST_WRITE;
            gnt_valid  = 1'b1;
            gnt_idx    = pick_idx;
            gnt_vec    = pick_grant;
            ptr_next   = (32'(pick_idx) == NREQ - 1) ? '0 : pick_idx + PW'(1);
`ifdef ARB_LOCK_EN
            if (LOCK[pick_idx]) begin
                state_next    = ST_LOCKED;
                owner_next    = pick_idx;
                lock_cnt_next = CW'(1);
            end
`endif
        end
    end

    // Output decode: address to one-hot CE, out-of-range flags ERR instead.
    always_comb begin
        gnt_addr  = ADDR[32'(gnt_idx) * AW +: AW];
        ack_next  = gnt_vec;
        ce_next   = '0;
        err_next  = 1'b0;
        d_next    = D;
        busy_next = (state_next != ST_IDLE);
        if (gnt_valid) begin
            d_next   = WDATA[32'(gnt_idx) * DW +: DW];
            err_next = (32'(gnt_addr) >= NREG);
            for (int w = 0; w < int'(NREG); w++) begin
                ce_next[w] = (32'(gnt_addr) == 32'(w));
            end
        end
    end

    // Pointer, lock tracking and registered outputs.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ptr  <= '0;
            ACK  <= '0;
            CE   <= '0;
            D    <= '0;
            ERR  <= 1'b0;
            BUSY <= 1'b0;
`ifdef ARB_LOCK_EN
            owner    <= '0;
            lock_cnt <= '0;
`endif
        end else begin
            ptr  <= ptr_next;
            ACK  <= ack_next;
            CE   <= ce_next;
            D    <= d_next;
            ERR  <= err_next;
            BUSY <= busy_next;
`ifdef ARB_LOCK_EN
            owner    <= owner_next;
            lock_cnt <= lock_cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_regbank_ce_arbiter.sv
// Directed bench for regbank_ce_arbiter with a behavioural flop bank on CE/D.
module tb_regbank_ce_arbiter;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned NREG     = 8;
    localparam int unsigned DW       = 8;
    localparam int unsigned AW       = 4;
    localparam int unsigned LOCK_MAX = 16;

    logic                CLK;
    logic                RESETN;
    logic [NREQ-1:0]     REQ;
    logic [NREQ*AW-1:0]  ADDR;
    logic [NREQ*DW-1:0]  WDATA;
    logic [NREQ-1:0]     LOCK;
    logic [NREQ-1:0]     ACK;
    logic [NREG-1:0]     CE;
    logic [DW-1:0]       D;
    logic                ERR;
    logic                BUSY;

    logic [DW-1:0]       bank [NREG];
    logic                bank_clr;

    int n_cmp;
    int n_err;

    regbank_ce_arbiter #(
        .NREQ     (NREQ),
        .NREG     (NREG),
        .DW       (DW),
        .AW       (AW),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .REQ    (REQ),
        .ADDR   (ADDR),
        .WDATA  (WDATA),
        .LOCK   (LOCK),
        .ACK    (ACK),
        .CE     (CE),
        .D      (D),
        .ERR    (ERR),
        .BUSY   (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Flop bank driven by the arbiter; no reset so a cancelled write is visible.
    always_ff @(posedge CLK) begin
        for (int w = 0; w < int'(NREG); w++) begin
            if (bank_clr) begin
                bank[w] <= '0;
            end else if (CE[w]) begin
                bank[w] <= D;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input int addr, input int data);
        ADDR[i*AW +: AW]  = addr[AW-1:0];
        WDATA[i*DW +: DW] = data[DW-1:0];
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_ack;
        n_cmp    = 0;
        n_err    = 0;
        RESETN   = 1'b0;
        REQ      = '0;
        ADDR     = '0;
        WDATA    = '0;
        LOCK     = '0;
        bank_clr = 1'b1;

        // Scenario 1: all requesting through reset, then rr order 0..3.
        for (int i = 0; i < int'(NREQ); i++) set_req(i, i + 1, 'h10 + i);
        REQ = 4'b1111;
        tick();
        tick();
        bank_clr = 1'b0;
        check_eq("rst_ack",  32'(ACK),  32'h0);
        check_eq("rst_ce",   32'(CE),   32'h0);
        check_eq("rst_d",    32'(D),    32'h0);
        check_eq("rst_err",  32'(ERR),  32'h0);
        check_eq("rst_busy", 32'(BUSY), 32'h0);
        RESETN = 1'b1;
        for (int i = 0; i < int'(NREQ); i++) begin
            tick();
            check_eq("rr_ack",  32'(ACK),  32'(1) << i);
            check_eq("rr_ce",   32'(CE),   32'(1) << (i + 1));
            check_eq("rr_d",    32'(D),    32'('h10 + i));
            check_eq("rr_busy", 32'(BUSY), 32'h1);
            REQ[i] = 1'b0;
        end
        tick();
        check_eq("idle_ack",  32'(ACK),  32'h0);
        check_eq("idle_ce",   32'(CE),   32'h0);
        check_eq("idle_dhold", 32'(D),   32'h13);
        check_eq("idle_busy", 32'(BUSY), 32'h0);
        check_eq("bank1",     32'(bank[1]), 32'h10);
        check_eq("bank4",     32'(bank[4]), 32'h13);

        // Scenario 2: single write REQ[2] -> word 5.
        set_req(2, 5, 'hA5);
        REQ = 4'b0100;
        tick();
        check_eq("s2_ack", 32'(ACK), 32'h4);
        check_eq("s2_ce",  32'(CE),  32'h20);
        check_eq("s2_d",   32'(D),   32'hA5);
        check_eq("s2_err", 32'(ERR), 32'h0);
        REQ = '0;
        tick();
        check_eq("s2_ack_off", 32'(ACK), 32'h0);
        check_eq("s2_ce_off",  32'(CE),  32'h0);
        check_eq("s2_bank5",   32'(bank[5]), 32'hA5);

        // Scenario 3: out-of-range address.
        set_req(1, 9, 'h5A);
        REQ = 4'b0010;
        tick();
        check_eq("s3_ack", 32'(ACK), 32'h2);
        check_eq("s3_err", 32'(ERR), 32'h1);
        check_eq("s3_ce",  32'(CE),  32'h0);
        check_eq("s3_d",   32'(D),   32'h5A);
        REQ = '0;
        tick();
        check_eq("s3_err_off", 32'(ERR), 32'h0);
        check_eq("s3_bank1",   32'(bank[1]), 32'h10);
        check_eq("s3_bank5",   32'(bank[5]), 32'hA5);

        // Scenario 4: reset while CE is asserted cancels the write.
        set_req(0, 3, 'h33);
        REQ = 4'b0001;
        tick();
        check_eq("s4_ack", 32'(ACK), 32'h1);
        REQ = '0;
        tick();
        check_eq("s4_bank3_pre", 32'(bank[3]), 32'h33);
        set_req(0, 3, 'hCC);
        REQ = 4'b0001;
        tick();
        check_eq("s4_ce", 32'(CE), 32'h08);
        RESETN = 1'b0;
        #1;
        check_eq("s4_rst_ce",   32'(CE),   32'h0);
        check_eq("s4_rst_ack",  32'(ACK),  32'h0);
        check_eq("s4_rst_busy", 32'(BUSY), 32'h0);
        tick();
        check_eq("s4_bank3_kept", 32'(bank[3]), 32'h33);
        REQ    = '0;
        RESETN = 1'b1;
        tick();

        // Scenario 5/6: REQ[0] with LOCK[0] and REQ[3] held for 20 cycles.
        set_req(0, 2, 'hC0);
        set_req(3, 6, 'hC3);
        LOCK = 4'b0001;
        REQ  = 4'b1001;
        for (int c = 0; c < 20; c++) begin
            tick();
`ifdef ARB_LOCK_EN
            exp_ack = (c == 16) ? 32'h8 : 32'h1;
`else
            exp_ack = (c % 2 == 1) ? 32'h8 : 32'h1;
`endif
            check_eq("s5_ack", 32'(ACK), exp_ack);
            check_eq("s5_ce",  32'(CE),  (exp_ack == 32'h1) ? 32'h04 : 32'h40);
        end
        REQ  = '0;
        LOCK = '0;
        tick();
        check_eq("s5_ack_off", 32'(ACK), 32'h0);
        check_eq("s5_busy_off", 32'(BUSY), 32'h0);
        check_eq("s5_bank6", 32'(bank[6]), 32'hC3);
        check_eq("s5_bank2", 32'(bank[2]), 32'hC0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
